// File: rtl/alu_pkg.sv
// Shared constants for the two-client ALU sequencer: opcodes, FSM encoding, divide-by-zero value.
package alu_pkg;

    // Opcodes carried on req*_sel
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_DIV = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    // Sequencer FSM encoding
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StDiv  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    // Result reported for a divide with a zero divisor
    localparam logic [7:0] DIVZERO_RESULT = 8'hFF;

endpackage

// File: rtl/alu_div8.sv
// Restoring unsigned divider: one quotient bit per cycle, DIV_CYCLES iterations after start_i.
// done_o flags the cycle whose iteration is the last one; quotient_o is the quotient as it
// will stand after the current iteration, so the caller can register it on that same edge.
module alu_div8
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DIV_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o
);

    localparam int unsigned CntW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifts out the top, quotient bits shift in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quo_nxt;
    logic             last;

    // One restoring step: trial subtract, keep it only if it did not go negative
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        quo_nxt   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        last      = busy_q && (cnt_q == CntW'(DIV_CYCLES - 1));

        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
        end else if (busy_q) begin
            rem_d = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
            quo_d = quo_nxt;
            cnt_d = cnt_q + CntW'(1);
            if (last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    // Divider state, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = last;
    assign quotient_o = quo_nxt;

endmodule

// File: rtl/alu_arbiter_seq.sv
// Two-requester front end for a shared 8-bit ALU: round-robin grant, single-cycle ADD/SUB/AND,
// multi-cycle DIV through alu_div8, and a response held until the consumer takes it.
module alu_arbiter_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DIV_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_err
);

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;

    logic             idle, gnt0, gnt1, accept;
    logic [1:0]       sel_w;
    logic [WIDTH-1:0] a_w, b_w;
    logic [WIDTH:0]   sum, dif;

    logic             div_start, div_busy, div_done;
    logic [WIDTH-1:0] div_quotient;

    // Round-robin grant: on a tie the requester not granted last time wins
    always_comb begin
        idle       = (state_q == StIdle) && !rst;
        gnt1       = req1_valid && (!req0_valid || !last_grant_q);
        gnt0       = req0_valid && !gnt1;
        req0_ready = idle && gnt0;
        req1_ready = idle && gnt1;
        accept     = req0_ready || req1_ready;
        sel_w      = gnt1 ? req1_sel : req0_sel;
        a_w        = gnt1 ? req1_a   : req0_a;
        b_w        = gnt1 ? req1_b   : req0_b;
        sum        = {1'b0, a_w} + {1'b0, b_w};
        dif        = {1'b0, a_w} - {1'b0, b_w};
    end

    // Sequencer next state and response datapath
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        res_d        = res_q;
        carry_d      = carry_q;
        err_d        = err_q;
        div_start    = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    last_grant_d = gnt1;
                    id_d         = gnt1;
                    carry_d      = 1'b0;
                    err_d        = 1'b0;
                    state_d      = StResp;
                    unique case (sel_w)
                        ALU_ADD: begin
                            res_d   = sum[WIDTH-1:0];
                            carry_d = sum[WIDTH];
                        end
                        ALU_SUB: begin
                            res_d   = dif[WIDTH-1:0];
                            carry_d = dif[WIDTH];
                        end
                        ALU_AND: res_d = a_w & b_w;
                        ALU_DIV: begin
                            if (b_w == '0) begin
                                res_d = WIDTH'(DIVZERO_RESULT);
                                err_d = 1'b1;
                            end else begin
                                div_start = 1'b1;
                                state_d   = StDiv;
                            end
                        end
                    endcase
                end
            end
            StDiv: begin
                // Divider idle while we wait on it cannot happen; recover rather than hang
                if (!div_busy) begin
                    state_d = StIdle;
                end else if (div_done) begin
                    res_d   = div_quotient;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            res_q        <= '0;
            carry_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            res_q        <= res_d;
            carry_q      <= carry_d;
            err_q        <= err_d;
        end
    end

    alu_div8 #(
        .WIDTH      (WIDTH),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (a_w),
        .divisor_i  (b_w),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quotient)
    );

    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_carry  = carry_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Directed bench for alu_arbiter_seq with a response scoreboard and latency tracking.
module tb_alu_arbiter_seq;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef struct {
        logic       id;
        logic [7:0] result;
        logic       carry;
        logic       err;
        int         lat;
    } exp_t;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] a;
        logic [7:0] b;
    } op_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0] req0_sel = '0, req1_sel = '0;
    logic       rsp_valid, rsp_id, rsp_carry, rsp_err;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_result;

    int   n_checks = 0;
    int   n_errs   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    int   acc_q[$];

    logic       prev_valid = 1'b0, prev_ready = 1'b0;
    logic       h_id, h_carry, h_err;
    logic [7:0] h_res;
    exp_t       mon_e;

    alu_arbiter_seq #(
        .WIDTH      (8),
        .DIV_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [1:0] sel,
                                   input logic [7:0] a, input logic [7:0] b);
        exp_t       e;
        logic [8:0] t;
        e.id = id; e.carry = 1'b0; e.err = 1'b0; e.lat = 1; e.result = '0;
        case (sel)
            OP_ADD: begin
                t = {1'b0, a} + {1'b0, b};
                e.result = t[7:0];
                e.carry  = t[8];
            end
            OP_SUB: begin
                e.result = a - b;
                e.carry  = (a < b);
            end
            OP_DIV: begin
                if (b == 8'h00) begin
                    e.result = 8'hFF;
                    e.err    = 1'b1;
                end else begin
                    e.result = a / b;
                    e.lat    = 9;
                end
            end
            default: e.result = a & b;
        endcase
        return e;
    endfunction

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input op_t op);
        if (id == 0) begin
            req0_valid = 1'b1; req0_sel = op.sel; req0_a = op.a; req0_b = op.b;
        end else begin
            req1_valid = 1'b1; req1_sel = op.sel; req1_a = op.a; req1_b = op.b;
        end
    endtask

    task automatic push_exp(input int id, input op_t op);
        sb.push_back(model(id[0], op.sel, op.a, op.b));
    endtask

    task automatic drive(input int id, input logic [1:0] sel, input logic [7:0] a,
                         input logic [7:0] b);
        op_t op;
        op.sel = sel; op.a = a; op.b = b;
        push_exp(id, op);
        set_req(id, op);
    endtask

    // Waits for the given requester to be accepted, then drops its valid
    task automatic wait_accept(input int id, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            #1;
            if (id == 0 ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
                acc_q.push_back(cyc + 1);
                done = 1'b1;
            end
            at_edge();
            if (done) begin
                if (id == 0) req0_valid = 1'b0;
                else         req1_valid = 1'b0;
            end
        end
        check($sformatf("accept_req%0d", id), {31'd0, done}, 32'd1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) at_edge();
        check("drain_empty", sb.size(), 0);
    endtask

    // Response monitor: compare on first cycle of rsp_valid, check hold during stalls
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            check("busy_ready0", {31'd0, req0_ready}, 32'd0);
            check("busy_ready1", {31'd0, req1_ready}, 32'd0);
            if (!prev_valid) begin
                if (sb.size() == 0 || acc_q.size() == 0) begin
                    check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    mon_e = sb[0];
                    check("rsp_latency", cyc - acc_q[0] + 1, mon_e.lat);
                    check("rsp_id", {31'd0, rsp_id}, {31'd0, mon_e.id});
                    check("rsp_result", {24'd0, rsp_result}, {24'd0, mon_e.result});
                    check("rsp_carry", {31'd0, rsp_carry}, {31'd0, mon_e.carry});
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
                end
            end else if (!prev_ready) begin
                check("hold_id", {31'd0, rsp_id}, {31'd0, h_id});
                check("hold_result", {24'd0, rsp_result}, {24'd0, h_res});
                check("hold_carry", {31'd0, rsp_carry}, {31'd0, h_carry});
                check("hold_err", {31'd0, rsp_err}, {31'd0, h_err});
            end
            if (rsp_ready && sb.size() != 0) begin
                void'(sb.pop_front());
                if (acc_q.size() != 0) void'(acc_q.pop_front());
            end
        end
        prev_valid = rsp_valid && !rst;
        prev_ready = rsp_ready;
        h_id = rsp_id; h_res = rsp_result; h_carry = rsp_carry; h_err = rsp_err;
    end

    initial begin
        op_t ops0[2];
        op_t ops1[2];
        int  i0, i1, ng;
        logic exp_g, a0, a1;

        // Reset state; requester 0 valid during reset must not see ready
        at_edge();
        req0_valid = 1'b1;
        at_edge();
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_id", {31'd0, rsp_id}, 32'd0);
        check("rst_result", {24'd0, rsp_result}, 32'd0);
        check("rst_carry", {31'd0, rsp_carry}, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        req0_valid = 1'b0;
        rst = 1'b0;
        at_edge();

        // Single-cycle ops
        drive(0, OP_ADD, 8'h33, 8'h04);
        wait_accept(0, 10);
        drain(20);
        drive(1, OP_SUB, 8'hFF, 8'h01);
        wait_accept(1, 10);
        drain(20);
        drive(1, OP_SUB, 8'h00, 8'h01);
        wait_accept(1, 10);
        drain(20);

        // Divide; a second request waits with no ready until the response is taken
        drive(0, OP_DIV, 8'hF0, 8'h0F);
        wait_accept(0, 10);
        drive(1, OP_DIV, 8'hAA, 8'h00);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rsp_valid) break;
            check("div_ready0", {31'd0, req0_ready}, 32'd0);
            check("div_ready1", {31'd0, req1_ready}, 32'd0);
            at_edge();
        end
        wait_accept(1, 30);
        drive(1, OP_AND, 8'hAA, 8'h55);
        wait_accept(1, 30);
        drain(40);

        // Both valid from reset: grants alternate 0,1,0,1
        rst = 1'b1;
        at_edge();
        rst = 1'b0;
        ops0[0] = '{OP_ADD, 8'h10, 8'h20};
        ops0[1] = '{OP_AND, 8'hF0, 8'h3C};
        ops1[0] = '{OP_SUB, 8'h50, 8'h10};
        ops1[1] = '{OP_ADD, 8'hFF, 8'h02};
        push_exp(0, ops0[0]);
        push_exp(1, ops1[0]);
        push_exp(0, ops0[1]);
        push_exp(1, ops1[1]);
        set_req(0, ops0[0]);
        set_req(1, ops1[0]);
        i0 = 0; i1 = 0; ng = 0; exp_g = 1'b0;
        for (int c = 0; c < 80 && ng < 4; c++) begin
            #1;
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (a0 || a1) begin
                check("tie_onehot", {31'd0, a0 & a1}, 32'd0);
                check("tie_grant", {31'd0, a1}, {31'd0, exp_g});
                acc_q.push_back(cyc + 1);
                exp_g = ~exp_g;
                ng++;
            end
            at_edge();
            if (a0) begin
                i0++;
                if (i0 < 2) set_req(0, ops0[i0]);
                else        req0_valid = 1'b0;
            end
            if (a1) begin
                i1++;
                if (i1 < 2) set_req(1, ops1[i1]);
                else        req1_valid = 1'b0;
            end
        end
        check("tie_count", ng, 4);
        drain(40);

        // Consumer stall: response held, other requester blocked
        rsp_ready = 1'b0;
        drive(0, OP_SUB, 8'h12, 8'h34);
        wait_accept(0, 10);
        drive(1, OP_ADD, 8'h80, 8'h80);
        repeat (5) at_edge();
        check("stall_valid", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        wait_accept(1, 20);
        drain(20);

        // Reset part-way through a divide drops the op
        drive(0, OP_DIV, 8'h64, 8'h03);
        wait_accept(0, 10);
        repeat (3) at_edge();
        rst = 1'b1;
        at_edge();
        void'(sb.pop_back());
        void'(acc_q.pop_back());
        check("mrst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mrst_id", {31'd0, rsp_id}, 32'd0);
        check("mrst_result", {24'd0, rsp_result}, 32'd0);
        check("mrst_carry", {31'd0, rsp_carry}, 32'd0);
        check("mrst_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            at_edge();
            check("mrst_quiet", {31'd0, rsp_valid}, 32'd0);
        end

        // After reset requester 0 wins a tie
        drive(0, OP_ADD, 8'h01, 8'h02);
        drive(1, OP_AND, 8'h0F, 8'hFC);
        #1;
        check("mrst_tie_ready0", {31'd0, req0_ready}, 32'd1);
        check("mrst_tie_ready1", {31'd0, req1_ready}, 32'd0);
        wait_accept(0, 5);
        wait_accept(1, 20);
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/alu_arbiter_seq.md
# alu_arbiter_seq

Shares one 8-bit ALU between two requesters and sequences each operation to completion. Round-robin arbitration, operand capture, a multi-cycle divide, and a held response with a valid/ready handshake. It sits between the two client blocks and the arithmetic datapath, and replaces free-running combinational ALU use wherever more than one client needs results.

## Interface
Parameters:
- WIDTH, 8, operand/result width; only 8 is verified.
- DIV_CYCLES, WIDTH, iterations of the restoring divider; must equal WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an op.
- req0_ready  output  1  requester 0 op accepted this cycle.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_sel  input  2  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_id  output  1  index of the requester that owns the result.
- rsp_result  output  WIDTH  result.
- rsp_carry  output  1  carry out for ADD, borrow for SUB, 0 otherwise.
- rsp_err  output  1  divide by zero.

## Operation
Opcodes:
- 00 ADD: A+B mod 256.
- 01 SUB: A−B mod 256.
- 10 DIV: unsigned A/B quotient; remainder is discarded.
- 11 AND: A&B.

FSM states are IDLE, DIV, RESP.

IDLE:
- Grant logic picks the winning requester combinationally. req*_ready=1 only for the winner, and only in IDLE.
- An accept is valid&&ready. On accept, capture a, b, sel and id.
- ADD/SUB/AND: compute at accept, register the result, go to RESP.
- DIV with B==0: rsp_result=8'hFF, rsp_err=1, rsp_carry=0, go to RESP.
- DIV with B!=0: load the divider and go to DIV.

DIV:
- One restoring-divide iteration per cycle, count 0..DIV_CYCLES−1.
- After the last iteration, register the quotient and go to RESP.

RESP:
- rsp_valid=1. All rsp_* outputs are held stable until rsp_ready=1.
- Return to IDLE on the cycle after the handshake.

Arbitration:
- A last_grant register updates on every accept.
- If both requesters are valid, the one not last granted wins. If only one is valid, it wins regardless.
- last_grant resets to 1, so requester 0 wins the first tie.

Other rules:
- Requesters must hold valid and their fields stable until accepted; req_valid may not drop before acceptance.
- While busy (DIV/RESP), both readys are 0 and requests wait.

## Timing
- Reset: state=IDLE, last_grant=1, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_err=0, req0_ready=0, req1_ready=0, divider count=0.
- ADD/SUB/AND, and DIV by zero: accept at edge N, rsp_valid=1 from cycle N+1.
- DIV with B!=0: accept at edge N, rsp_valid=1 from cycle N+1+DIV_CYCLES (N+9).
- Minimum issue interval: response handshake at edge M, IDLE at M+1, next accept no earlier than edge M+1. Throughput is at most one op per 2 cycles.
- rsp_ready high while rsp_valid=0 is ignored.
- Reset asserted mid-DIV or mid-RESP: the op is dropped with no response, and everything returns to reset values at the next edge.
- Simultaneous rsp handshake and new request valid: the new request is not accepted that cycle.

## Structure
- Shared package alu_pkg holds:
  - opcode constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_DIV=2'b10, ALU_AND=2'b11;
  - the FSM state encoding (IDLE, DIV, RESP);
  - DIVZERO_RESULT=8'hFF.
- One sub-module, alu_div8: restoring divider with start, busy/done, dividend, divisor, quotient, iterated DIV_CYCLES times.
- Arbiter, ADD/SUB/AND datapath and FSM stay in the top level.

## Test plan
- Req0 ADD A=8'h33 B=8'h04, rsp_ready=1 → rsp_valid one cycle after accept, result 8'h37, carry=0, err=0, id=0.
- Req1 SUB A=8'hFF B=8'h01 → result 8'hFE, carry(borrow)=0. Then SUB A=8'h00 B=8'h01 → result 8'hFF, borrow=1.
- Req0 DIV A=8'hF0 B=8'h0F → rsp_valid exactly 9 cycles after accept, result 8'h10, err=0. Readys stay 0 throughout.
- Req1 DIV A=8'hAA B=8'h00 → next cycle: result 8'hFF, err=1. AND A=8'hAA B=8'h55 → result 8'h00.
- Both requesters valid continuously, rsp_ready=1 → grants alternate 0,1,0,1 after reset. A rsp_ready stall of 5 cycles holds all rsp_* stable and blocks accepts.
- Assert rst 4 cycles into a DIV → no response emitted, all outputs at reset values. The next request is accepted normally, and requester 0 wins a tie.
